// File: rtl/status_stack_reg.sv
// CPU status register (ALU flags, interrupt mask, mode) with a hardware
// save/restore stack used on trap entry and return-from-interrupt.
module status_stack_reg #(
    parameter int               ALU_W       = 4,
    parameter int               DEPTH       = 4,
    parameter logic [ALU_W+1:0] INITIAL_VAL = {1'b1, 1'b0, {ALU_W{1'b0}}},
    parameter bit               PROTECT     = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    output tri   [ALU_W+1:0]             a,
    output tri   [ALU_W+1:0]             b,
    input  logic                         oe_a,
    input  logic                         oe_b,
    input  logic [ALU_W+1:0]             in,
    input  logic                         ld,
    input  logic [ALU_W-1:0]             alu_status_in,
    input  logic                         ld_alu_status,
    input  logic                         imask_in,
    input  logic                         ld_imask,
    input  logic                         mode_in,
    input  logic                         ld_mode,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clr_err,
    output logic [ALU_W+1:0]             value,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf,
    output logic                         unf,
    output logic                         priv_err
);

    localparam int W  = ALU_W + 2;
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MODE_BIT  = ALU_W + 1;
    localparam int IMASK_BIT = ALU_W;

    logic [W-1:0]  value_q, value_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          privErr_q, privErr_d;
    logic [W-1:0]  stackMem_q [DEPTH];

    logic          stackWe;
    logic [AW-1:0] pushIdx;
    logic [AW-1:0] popIdx;
    logic [W-1:0]  fieldVal;
    logic          isFull;
    logic          isEmpty;
    logic          userMode;

    assign isFull   = (depth_q == DW'(DEPTH));
    assign isEmpty  = (depth_q == '0);
    assign pushIdx  = AW'(depth_q);
    assign popIdx   = AW'(depth_q - DW'(1));
    assign userMode = PROTECT && !value_q[MODE_BIT];

    // Priority: push beats pop, and any stack operation masks the field loads.
    // Error flags are cleared first so that a same-cycle set wins over clr_err.
    always_comb begin
        value_d   = value_q;
        depth_d   = depth_q;
        ovf_d     = ovf_q & ~clr_err;
        unf_d     = unf_q & ~clr_err;
        privErr_d = privErr_q & ~clr_err;
        stackWe   = 1'b0;
        fieldVal  = value_q;

        if (push) begin
            if (isFull) begin
                ovf_d = 1'b1;
            end else begin
                stackWe = 1'b1;
                depth_d = depth_q + DW'(1);
            end
            value_d = {1'b1, 1'b1, value_q[ALU_W-1:0]};
        end else if (pop) begin
            if (isEmpty) begin
                unf_d = 1'b1;
            end else begin
                value_d = stackMem_q[popIdx];
                depth_d = depth_q - DW'(1);
            end
        end else begin
            if (ld) begin
                fieldVal = in;
            end
            if (ld_alu_status) begin
                fieldVal[ALU_W-1:0] = alu_status_in;
            end
            if (ld_imask) begin
                fieldVal[IMASK_BIT] = imask_in;
            end
            if (ld_mode) begin
                fieldVal[MODE_BIT] = mode_in;
            end
            // User mode keeps imask/mode; protection looks at the pre-edge mode.
            if (userMode) begin
                fieldVal[MODE_BIT:IMASK_BIT] = value_q[MODE_BIT:IMASK_BIT];
                if (ld || ld_imask || ld_mode) begin
                    privErr_d = 1'b1;
                end
            end
            value_d = fieldVal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q   <= INITIAL_VAL;
            depth_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            privErr_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            depth_q   <= depth_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            privErr_q <= privErr_d;
        end
    end

    // Stack storage needs no reset; entries are only read below depth_q.
    always_ff @(posedge clk) begin
        if (stackWe && !rst) begin
            stackMem_q[pushIdx] <= value_q;
        end
    end

    assign a        = oe_a ? value_q : 'z;
    assign b        = oe_b ? value_q : 'z;
    assign value    = value_q;
    assign depth    = depth_q;
    assign full     = isFull;
    assign empty    = isEmpty;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign priv_err = privErr_q;

endmodule

// File: tb/tb_status_stack_reg.sv
// Testbench for status_stack_reg: a behavioural model pushes expected state to
// a queue each cycle, and each scenario task pops and compares after the edge.
module tb_status_stack_reg;

    localparam int W = 6;

    logic       clk = 1'b0;
    logic       rst, oe_a, oe_b, ld, ldAlu, ldIm, ldMode, push, pop, clrErr;
    logic [5:0] dIn;
    logic [3:0] aluIn;
    logic       imIn, modeIn;
    tri   [5:0] busA;
    tri   [5:0] busB;
    logic [5:0] value;
    logic [2:0] depth;
    logic       full, empty, ovf, unf, privErr;

    int nRun  = 0;
    int nFail = 0;

    typedef struct {
        logic [5:0] value;
        logic [2:0] depth;
        logic       ovf;
        logic       unf;
        logic       perr;
        logic       oeA;
        logic       oeB;
    } exp_t;

    exp_t sbQ[$];

    logic [5:0] mValue;
    int         mDepth;
    logic [5:0] mStack [4];
    logic       mOvf, mUnf, mPerr;

    status_stack_reg dut (
        .clk(clk), .rst(rst), .a(busA), .b(busB), .oe_a(oe_a), .oe_b(oe_b),
        .in(dIn), .ld(ld), .alu_status_in(aluIn), .ld_alu_status(ldAlu),
        .imask_in(imIn), .ld_imask(ldIm), .mode_in(modeIn), .ld_mode(ldMode),
        .push(push), .pop(pop), .clr_err(clrErr), .value(value), .depth(depth),
        .full(full), .empty(empty), .ovf(ovf), .unf(unf), .priv_err(privErr)
    );

    // Released bus A floats high and bus B floats low, so Z is observable.
    for (genvar g = 0; g < W; g++) begin : gPull
        pullup   (busA[g]);
        pulldown (busB[g]);
    end

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    task automatic modelStep();
        logic       user;
        logic [3:0] nAlu;
        logic       nIm, nMode;
        if (rst) begin
            mValue = 6'b10_0000;
            mDepth = 0;
            mOvf = 1'b0; mUnf = 1'b0; mPerr = 1'b0;
            return;
        end
        user = (mValue[5] == 1'b0);
        if (clrErr) begin
            mOvf = 1'b0; mUnf = 1'b0; mPerr = 1'b0;
        end
        if (push) begin
            if (mDepth == 4) mOvf = 1'b1;
            else begin
                mStack[mDepth] = mValue;
                mDepth++;
            end
            mValue[5:4] = 2'b11;
        end else if (pop) begin
            if (mDepth == 0) mUnf = 1'b1;
            else begin
                mDepth--;
                mValue = mStack[mDepth];
            end
        end else begin
            nAlu  = ldAlu  ? aluIn  : (ld ? dIn[3:0] : mValue[3:0]);
            nIm   = ldIm   ? imIn   : (ld ? dIn[4]   : mValue[4]);
            nMode = ldMode ? modeIn : (ld ? dIn[5]   : mValue[5]);
            if (user) begin
                nIm   = mValue[4];
                nMode = mValue[5];
                if (ld || ldIm || ldMode) mPerr = 1'b1;
            end
            mValue = {nMode, nIm, nAlu};
        end
    endtask

    // Runs the model on the inputs now applied, queues the expectation, clocks
    // the DUT and returns control inputs to idle (bus enables are kept).
    task automatic tick();
        exp_t e;
        modelStep();
        e.value = mValue;
        e.depth = 3'(mDepth);
        e.ovf   = mOvf;
        e.unf   = mUnf;
        e.perr  = mPerr;
        e.oeA   = oe_a;
        e.oeB   = oe_b;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        rst = 0; ld = 0; ldAlu = 0; ldIm = 0; ldMode = 0;
        push = 0; pop = 0; clrErr = 0;
    endtask

    function automatic logic [25:0] expVec(exp_t e);
        return {e.value, e.depth, e.depth == 3'd4, e.depth == 3'd0, e.ovf, e.unf,
                e.perr, (e.oeA ? e.value : 6'h3f), (e.oeB ? e.value : 6'h00)};
    endfunction

    function automatic logic [25:0] obsVec();
        return {value, depth, full, empty, ovf, unf, privErr, busA, busB};
    endfunction

    task automatic test_reset();
        exp_t e;
        rst = 1;
        tick();
        e = sbQ.pop_front();
        nRun++;
        if (obsVec() !== expVec(e)) begin
            nFail++;
            $display("[TB] FAIL reset_state: got %h want %h", obsVec(), expVec(e));
        end
        nRun++;
        if ({value, depth, empty} !== {6'b10_0000, 3'd0, 1'b1}) begin
            nFail++;
            $display("[TB] FAIL reset_literal: got %b want %b", {value, depth, empty}, {6'b10_0000, 3'd0, 1'b1});
        end
        oe_a = 1;
        #1;
        nRun++;
        if ({busA, busB} !== {6'b10_0000, 6'b00_0000}) begin
            nFail++;
            $display("[TB] FAIL bus_a_enable: got %b want %b", {busA, busB}, {6'b10_0000, 6'b00_0000});
        end
        oe_a = 0;
        oe_b = 1;
        #1;
        nRun++;
        if ({busA, busB} !== {6'b11_1111, 6'b10_0000}) begin
            nFail++;
            $display("[TB] FAIL bus_b_enable: got %b want %b", {busA, busB}, {6'b11_1111, 6'b10_0000});
        end
        oe_b = 0;
    endtask

    task automatic test_field_loads();
        exp_t e;
        ld = 1; dIn = 6'b11_1010; ldAlu = 1; aluIn = 4'b0101;
        tick();
        e = sbQ.pop_front();
        nRun++;
        if (obsVec() !== expVec(e) || value !== 6'b11_0101) begin
            nFail++;
            $display("[TB] FAIL ld_plus_alu: got %h want %h (value %b)", obsVec(), expVec(e), value);
        end
        ldMode = 1; modeIn = 0;
        tick();
        e = sbQ.pop_front();
        nRun++;
        if (obsVec() !== expVec(e) || value !== 6'b01_0101) begin
            nFail++;
            $display("[TB] FAIL ld_mode_only: got %h want %h (value %b)", obsVec(), expVec(e), value);
        end
    endtask

    task automatic test_protection();
        exp_t e;
        rst = 1;
        tick();
        void'(sbQ.pop_front());
        ld = 1; dIn = 6'b00_0011;
        tick();
        e = sbQ.pop_front();
        nRun++;
        if (obsVec() !== expVec(e) || value !== 6'b00_0011) begin
            nFail++;
            $display("[TB] FAIL super_to_user: got %h want %h (value %b)", obsVec(), expVec(e), value);
        end
        ld = 1; dIn = 6'b11_1100;
        tick();
        e = sbQ.pop_front();
        nRun++;
        if (obsVec() !== expVec(e) || {value, privErr} !== {6'b00_1100, 1'b1}) begin
            nFail++;
            $display("[TB] FAIL user_ld_protect: got %h want %h (value %b)", obsVec(), expVec(e), value);
        end
        ldIm = 1; imIn = 1; clrErr = 1;
        tick();
        e = sbQ.pop_front();
        nRun++;
        if (obsVec() !== expVec(e) || privErr !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL set_beats_clear: got %h want %h", obsVec(), expVec(e));
        end
        clrErr = 1;
        tick();
        e = sbQ.pop_front();
        nRun++;
        if (obsVec() !== expVec(e) || privErr !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL clr_err: got %h want %h", obsVec(), expVec(e));
        end
    endtask

    task automatic test_nesting();
        exp_t e;
        logic [5:0] wantVal [5] = '{6'b11_0011, 6'b11_1111, 6'b11_1111, 6'b11_1111, 6'b00_0011};
        logic [2:0] wantDep [5] = '{3'd1, 3'd1, 3'd2, 3'd1, 3'd0};
        rst = 1;
        tick();
        void'(sbQ.pop_front());
        ld = 1; dIn = 6'b00_0011;
        tick();
        void'(sbQ.pop_front());
        for (int i = 0; i < 5; i++) begin
            case (i)
                0, 2: push = 1;
                1: begin ldAlu = 1; aluIn = 4'b1111; end
                default: pop = 1;
            endcase
            tick();
            e = sbQ.pop_front();
            nRun++;
            if (obsVec() !== expVec(e) || {value, depth} !== {wantVal[i], wantDep[i]}) begin
                nFail++;
                $display("[TB] FAIL nesting_step%0d: got %h want %h (value %b depth %0d)",
                         i, obsVec(), expVec(e), value, depth);
            end
        end
    endtask

    task automatic test_boundaries();
        exp_t e;
        rst = 1;
        tick();
        void'(sbQ.pop_front());
        ld = 1; dIn = 6'b00_0011;
        tick();
        void'(sbQ.pop_front());
        for (int i = 0; i < 5; i++) begin
            push = 1;
            tick();
            e = sbQ.pop_front();
            nRun++;
            if (obsVec() !== expVec(e)) begin
                nFail++;
                $display("[TB] FAIL push_fill%0d: got %h want %h", i, obsVec(), expVec(e));
            end
        end
        nRun++;
        if ({depth, full, ovf, value[5:4]} !== {3'd4, 1'b1, 1'b1, 2'b11}) begin
            nFail++;
            $display("[TB] FAIL full_boundary: got %b want %b", {depth, full, ovf, value[5:4]}, {3'd4, 1'b1, 1'b1, 2'b11});
        end
        clrErr = 1;
        tick();
        void'(sbQ.pop_front());
        for (int i = 0; i < 5; i++) begin
            pop = 1;
            tick();
            e = sbQ.pop_front();
            nRun++;
            if (obsVec() !== expVec(e)) begin
                nFail++;
                $display("[TB] FAIL pop_drain%0d: got %h want %h", i, obsVec(), expVec(e));
            end
        end
        nRun++;
        if ({depth, empty, unf, value} !== {3'd0, 1'b1, 1'b1, 6'b00_0011}) begin
            nFail++;
            $display("[TB] FAIL empty_boundary: got %b want %b", {depth, empty, unf, value}, {3'd0, 1'b1, 1'b1, 6'b00_0011});
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        rst = 1;
        tick();
        void'(sbQ.pop_front());
        ld = 1; dIn = 6'b10_0110;
        tick();
        void'(sbQ.pop_front());
        push = 1;
        tick();
        void'(sbQ.pop_front());
        push = 1; pop = 1;
        tick();
        e = sbQ.pop_front();
        nRun++;
        if (obsVec() !== expVec(e) || depth !== 3'd2) begin
            nFail++;
            $display("[TB] FAIL push_pop_same: got %h want %h (depth %0d)", obsVec(), expVec(e), depth);
        end
        push = 1; ld = 1; dIn = 6'b00_1001;
        tick();
        e = sbQ.pop_front();
        nRun++;
        if (obsVec() !== expVec(e) || value !== 6'b11_0110) begin
            nFail++;
            $display("[TB] FAIL push_ld_same: got %h want %h (value %b)", obsVec(), expVec(e), value);
        end
        push = 1;
        tick();
        void'(sbQ.pop_front());
        push = 1;
        tick();
        void'(sbQ.pop_front());
        pop = 1;
        tick();
        void'(sbQ.pop_front());
        rst = 1; push = 1; ld = 1; dIn = 6'b01_1111;
        tick();
        e = sbQ.pop_front();
        nRun++;
        if (obsVec() !== expVec(e) || {value, depth, ovf, unf, privErr} !== {6'b10_0000, 3'd0, 3'b000}) begin
            nFail++;
            $display("[TB] FAIL reset_mid_stack: got %h want %h", obsVec(), expVec(e));
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int i = 0; i < 120; i++) begin
            rst    = ($urandom_range(0, 39) == 0);
            push   = ($urandom_range(0, 3) == 0);
            pop    = ($urandom_range(0, 3) == 0);
            ld     = ($urandom_range(0, 3) == 0);
            ldAlu  = ($urandom_range(0, 2) == 0);
            ldIm   = ($urandom_range(0, 4) == 0);
            ldMode = ($urandom_range(0, 4) == 0);
            clrErr = ($urandom_range(0, 7) == 0);
            oe_a   = 1'($urandom_range(0, 1));
            oe_b   = 1'($urandom_range(0, 1));
            dIn    = 6'($urandom_range(0, 63));
            aluIn  = 4'($urandom_range(0, 15));
            imIn   = 1'($urandom_range(0, 1));
            modeIn = 1'($urandom_range(0, 1));
            tick();
            e = sbQ.pop_front();
            nRun++;
            if (obsVec() !== expVec(e)) begin
                nFail++;
                $display("[TB] FAIL random_cycle%0d: got %h want %h", i, obsVec(), expVec(e));
            end
        end
        oe_a = 0;
        oe_b = 0;
    endtask

    initial begin
        rst = 0; oe_a = 0; oe_b = 0; ld = 0; ldAlu = 0; ldIm = 0; ldMode = 0;
        push = 0; pop = 0; clrErr = 0; dIn = '0; aluIn = '0; imIn = 0; modeIn = 0;
        mValue = '0; mDepth = 0; mOvf = 0; mUnf = 0; mPerr = 0;
        test_reset();
        test_field_loads();
        test_protection();
        test_nesting();
        test_boundaries();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule
